// File: rtl/tc_log_pkg.sv
// Shared widths and record layout for the terminal-count event logger.
`timescale 1ns/1ps
package tc_log_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 8;
    localparam int DROP_W    = 8;

    typedef struct packed {
        logic [TS_W_DEF-1:0]  ts;
        logic [CNT_W_DEF-1:0] cnt;
    } tc_rec_t;

    localparam int REC_W = $bits(tc_rec_t);

    // Saturating increment used by the dropped-event counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        logic [DROP_W-1:0] r;
        if (v == {DROP_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + DROP_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/tc_log_fifo.sv
// Synchronous FIFO with explicit occupancy register; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
`timescale 1ns/1ps
module tc_log_fifo #(
    parameter  int WIDTH = 20,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push_s, do_pop_s;

    assign empty_o = (level_q == LW'(0));
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Accept/next-state logic for pointers and occupancy.
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_o || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage, pointer and occupancy registers; reset discards all entries.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/tc_event_logger.sv
// Timestamps rising edges of the counter's terminal-count flag into a FIFO.
// Optional macro TC_LOG_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
`timescale 1ns/1ps
module tc_event_logger
    import tc_log_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ena,
    input  logic [CNT_W-1:0]        cnt_in,
    input  logic                    tc_in,
    input  logic                    rd_ready,
    input  logic                    clr_ovf,
    output logic                    rd_valid,
    output logic [TS_W+CNT_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    ovf
`ifdef TC_LOG_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]       drop_cnt
`endif
);

    logic [TS_W-1:0] ts_q, ts_d;
    logic            tc_prev_q;
    logic            ovf_q, ovf_d;
    logic            event_s, pop_s, push_s, drop_s;
    logic            full_s, empty_s;

    tc_log_fifo #(
        .WIDTH (TS_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  ({ts_q, cnt_in}),
        .data_o  (rd_data),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level)
    );

    assign rd_valid = !empty_s;
    assign ovf      = ovf_q;

    // Edge detect, push/drop decision and sticky overflow next state.
    always_comb begin
        event_s = ena && tc_in && !tc_prev_q;
        pop_s   = rd_valid && rd_ready;
        drop_s  = event_s && full_s && !pop_s;
        push_s  = event_s && !drop_s;
        ts_d    = ts_q + TS_W'(1);
        ovf_d   = ovf_q;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Free-running timestamp, previous tc level and overflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_q      <= '0;
            tc_prev_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ts_q      <= ts_d;
            tc_prev_q <= tc_in;
            ovf_q     <= ovf_d;
        end
    end

`ifdef TC_LOG_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    assign drop_cnt = drop_cnt_q;

    // Drop counter next state; a new drop beats a clear on the same edge.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_s) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end else if (clr_ovf) begin
            drop_cnt_d = '0;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_tc_event_logger.sv
// Directed bench for tc_event_logger: a default instance plus a TS_W=4 instance
// for timestamp wrap. Honours TC_LOG_DROP_CNT_EN when defined.
`timescale 1ns/1ps
module tb_tc_event_logger;
    import tc_log_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, ena, tc_in, rd_ready, clr_ovf;
    logic [3:0]  cnt_in;
    logic        rd_valid, ovf, s_rd_valid, s_ovf;
    logic [19:0] rd_data;
    logic [7:0]  s_rd_data;
    logic [3:0]  level, s_level;
`ifdef TC_LOG_DROP_CNT_EN
    logic [7:0]  drop_cnt, s_drop_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          ts_now = 0;
    logic [19:0] exp_q [$];
    logic [19:0] rec;

    tc_event_logger #(.CNT_W(4), .TS_W(16), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .cnt_in(cnt_in), .tc_in(tc_in),
        .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_valid(rd_valid),
        .rd_data(rd_data), .level(level), .ovf(ovf)
`ifdef TC_LOG_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    tc_event_logger #(.CNT_W(4), .TS_W(4), .DEPTH(8)) dut_small (
        .clk(clk), .reset_n(reset_n), .ena(ena), .cnt_in(cnt_in), .tc_in(tc_in),
        .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_valid(s_rd_valid),
        .rd_data(s_rd_data), .level(s_level), .ovf(s_ovf)
`ifdef TC_LOG_DROP_CNT_EN
        , .drop_cnt(s_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        if (reset_n) ts_now++;
        #1;
    endtask

    task automatic pulse(input logic [3:0] c);
        cnt_in = c;
        tc_in  = 1'b1;
        tick;
        tc_in  = 1'b0;
        tick;
    endtask

    function automatic logic [19:0] mk(input int ts, input logic [3:0] c);
        tc_rec_t r;
        r.ts  = 16'(ts);
        r.cnt = c;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset_n = 1'b0; ena = 1'b0; tc_in = 1'b0; rd_ready = 1'b0;
        clr_ovf = 1'b0; cnt_in = 4'h0;
        tick;
        tick;
        check_val("rst_valid", rd_valid, 0);
        check_val("rst_data", rd_data, 0);
        check_val("rst_level", level, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_s_level", s_level, 0);
`ifdef TC_LOG_DROP_CNT_EN
        check_val("rst_drop", drop_cnt, 0);
`endif

        // release 100 ps after an edge; first edge afterwards captures ts 0
        @(posedge clk);
        #0.1;
        reset_n = 1'b1; ena = 1'b1; tc_in = 1'b1; cnt_in = 4'h3;
        @(posedge clk);
        ts_now++;
        #1;
        check_val("first_valid", rd_valid, 1);
        check_val("first_data", rd_data, 20'h00003);
        check_val("first_level", level, 1);
        tc_in = 1'b0; rd_ready = 1'b1;
        tick;
        rd_ready = 1'b0;
        check_val("first_pop", level, 0);

        // single event at ts=5, tc held high 3 cycles
        guard = 0;
        while (ts_now != 5 && guard < 100) begin
            tick;
            guard++;
        end
        check_val("single_pre_valid", rd_valid, 0);
        cnt_in = 4'hF; tc_in = 1'b1;
        tick;
        check_val("single_valid", rd_valid, 1);
        check_val("single_data", rd_data, 20'h0005F);
        tick;
        tick;
        check_val("single_hold_level", level, 1);
        check_val("single_hold_data", rd_data, 20'h0005F);
        tc_in = 1'b0; rd_ready = 1'b1;
        tick;
        rd_ready = 1'b0;
        check_val("single_pop", level, 0);

        // gating: pulses with ena low, then ena rises while tc high
        ena = 1'b0; tc_in = 1'b1;
        tick;
        tc_in = 1'b0;
        tick;
        tc_in = 1'b1;
        tick;
        ena = 1'b1;
        tick;
        tick;
        check_val("gate_level", level, 0);
        check_val("gate_valid", rd_valid, 0);
        tc_in = 1'b0;
        tick;

        // overflow: 9 events with no reads
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(mk(ts_now, 4'(i)));
            pulse(4'(i));
        end
        check_val("ovf_level", level, 8);
        check_val("ovf_set", ovf, 1);
`ifdef TC_LOG_DROP_CNT_EN
        check_val("ovf_drop1", drop_cnt, 1);
`endif
        // a drop on the same edge as clr_ovf keeps the flag set
        cnt_in = 4'hC; tc_in = 1'b1; clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0; tc_in = 1'b0;
        tick;
        check_val("ovf_setwins", ovf, 1);
        check_val("ovf_setwins_level", level, 8);
`ifdef TC_LOG_DROP_CNT_EN
        check_val("ovf_drop2", drop_cnt, 2);
`endif
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        check_val("ovf_clr", ovf, 0);
`ifdef TC_LOG_DROP_CNT_EN
        check_val("ovf_drop_clr", drop_cnt, 0);
`endif
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("ovf_rd%0d", i), rd_data, exp_q[i]);
            tick;
        end
        rd_ready = 1'b0;
        check_val("ovf_drained", level, 0);

        // full with simultaneous push and pop
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(ts_now, 4'(8 + i)));
            pulse(4'(8 + i));
        end
        check_val("fpp_full", level, 8);
        check_val("fpp_head", rd_data, exp_q[0]);
        cnt_in = 4'h7;
        exp_q.push_back(mk(ts_now, 4'h7));
        tc_in = 1'b1; rd_ready = 1'b1;
        tick;
        tc_in = 1'b0; rd_ready = 1'b0;
        check_val("fpp_level", level, 8);
        check_val("fpp_ovf", ovf, 0);
        void'(exp_q.pop_front());
        check_val("fpp_newhead", rd_data, exp_q[0]);
        tick;
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("fpp_rd%0d", i), rd_data, exp_q[i]);
            tick;
        end
        check_val("fpp_drained", level, 0);

        // push with rd_ready high while empty: push only
        rec = mk(ts_now, 4'h2);
        cnt_in = 4'h2; tc_in = 1'b1;
        tick;
        tc_in = 1'b0;
        check_val("empty_pp_level", level, 1);
        check_val("empty_pp_data", rd_data, rec);
        tick;
        rd_ready = 1'b0;
        check_val("empty_pp_pop", level, 0);

        // reset mid-operation discards stored records
        pulse(4'h1);
        check_val("mid_pre_level", level, 1);
        reset_n = 1'b0;
        ts_now = 0;
        tick;
        check_val("mid_rst_level", level, 0);
        check_val("mid_rst_valid", rd_valid, 0);
        check_val("mid_rst_data", rd_data, 0);
        tick;
        reset_n = 1'b1;

        // timestamp wrap on the TS_W=4 instance: ts 14 and 17
        guard = 0;
        while (ts_now != 14 && guard < 100) begin
            tick;
            guard++;
        end
        pulse(4'hA);
        tick;
        pulse(4'hB);
        check_val("wrap_level", level, 2);
        check_val("wrap_s_level", s_level, 2);
        check_val("wrap_rec0", rd_data, 20'h000EA);
        check_val("wrap_s_rec0", s_rd_data, 8'hEA);
        rd_ready = 1'b1;
        tick;
        check_val("wrap_rec1", rd_data, 20'h0011B);
        check_val("wrap_s_rec1", s_rd_data, 8'h1B);
        tick;
        rd_ready = 1'b0;
        check_val("wrap_drained", s_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tc_event_logger.md
Name: tc_event_logger

Overview:
- Downstream consumer of the up/down counter.
- Watches the counter's count output and terminal-count flag, detects each terminal-count rising edge, timestamps it against a free-running cycle counter, and buffers the {timestamp, count} record in a small FIFO.
- Records are drained through a valid/ready read port by a host or checker stage.
- Lost events are flagged when the FIFO is full.

Parameters:
- CNT_W, 4, width of the counter value input.
- TS_W, 16, width of the free-running timestamp; wraps modulo 2^TS_W.
- DEPTH, 8, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ena  in  1  logging enable; edges seen while low are ignored.
- cnt_in  in  CNT_W  counter value (cnt_out of the counter).
- tc_in  in  1  terminal-count flag (term_cnt of the counter).
- rd_ready  in  1  consumer accepts the head record this cycle.
- clr_ovf  in  1  one-cycle pulse that clears the overflow flag.
- rd_valid  out  1  head record available.
- rd_data  out  TS_W+CNT_W  head record, {timestamp, count}.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky flag: at least one event was dropped.

Behaviour:
Reset
- Clock is clk. Reset is reset_n, synchronous and active-low; it is sampled only on the rising edge of clk.
- While reset_n is low: rd_valid=0, rd_data=0, level=0, ovf=0, timestamp=0, tc_prev=0, and the FIFO pointers are 0.
- Reset asserted mid-operation discards every stored record on that same edge.

Timestamp
- Increments by 1 on every clock with reset_n high, independent of ena.
- Wraps from 2^TS_W-1 to 0 with no flag.

Event detection
- Event at edge N when ena=1, tc_in=1 and tc_prev=0.
- tc_prev is updated every cycle, regardless of ena.
- A tc_in level held high produces exactly one event.
- A tc_in that is already high when ena rises produces no event.

Record capture and latency
- The record is {timestamp value before increment at edge N, cnt_in sampled at edge N}.
- The record is written at edge N.
- rd_valid is high in the cycle after edge N (1-cycle latency). There is no combinational bypass from input to output.

Read port
- rd_data is the head entry; it is stable while rd_valid=1 and rd_ready=0.
- A pop occurs at an edge where rd_valid=1 and rd_ready=1.
- rd_ready while empty has no effect.

Full and overflow
- With level=DEPTH and no pop at the same edge, a new event is dropped and ovf is set.
- Push and pop at the same edge while full: both succeed, level stays DEPTH, and ovf is not set.
- Push and pop at the same edge while empty: push only, since rd_valid was 0.
- ovf is cleared by clr_ovf. If clr_ovf and a new drop occur at the same edge, the set wins.

Arithmetic
- Pointers are log2(DEPTH) bits and wrap naturally.
- level = write count minus read count, held in an explicit register.

Optional Feature:
TC_LOG_DROP_CNT_EN
- Defined: adds output port drop_cnt, 8 bits.
  - Reset to 0.
  - Increments on every dropped event and saturates at 255.
  - Cleared by clr_ovf; increment wins on a simultaneous drop.
- Undefined: the port and its logic are absent; only the sticky ovf reports loss.

Decomposition:
- Package tc_log_pkg holds:
  - default widths;
  - record typedef tc_rec_t, a packed struct {ts, cnt};
  - constant REC_W.
- Sub-module tc_log_fifo: a synchronous FIFO with push/pop/full/empty/level, parameterised by width and depth. Edge detection, timestamp and the ovf logic stay in the top level.

Test Plan:
- Reset: hold reset_n low for 2 cycles and release at +100 ps after the edge -> all outputs 0; first timestamp captured is 0 at the first edge after release.
- Single event: ena=1, raise tc_in at the edge when timestamp=5, cnt_in=4'hF, hold tc_in high for 3 cycles -> exactly one record {16'd5, 4'hF}; rd_valid rises 1 cycle later.
- Gating: tc_in pulses with ena=0, then ena rises while tc_in is high -> level stays 0.
- Overflow: hold rd_ready=0 and generate 9 edges with DEPTH=8 -> level=8, ovf=1 (drop_cnt=1 with the macro defined); clr_ovf clears it; the 8 records read out in order.
- Full with simultaneous push/pop: level=8, event and rd_ready at the same edge -> level=8, ovf stays 0, the oldest record is popped and the newest is at the tail.
- Wrap: TS_W=4, events at timestamps 14 and 17 -> records carry ts 14 and 1.
